// File: rtl/watchdog_escalation_ctrl_if.sv
// Signal bundle between the watchdog escalation controller and its environment.
// The master side drives the watchdog level, the software ack and the cause clear; the slave side is the controller.
interface watchdog_escalation_ctrl_if;
  logic       interrupt;
  logic       irq_ack;
  logic       cause_clr;
  logic       irq_out;
  logic       sys_rst_n;
  logic       esc_cause;
  logic [7:0] esc_count;

  modport master (
    output interrupt, irq_ack, cause_clr,
    input  irq_out, sys_rst_n, esc_cause, esc_count
  );

  modport slave (
    input  interrupt, irq_ack, cause_clr,
    output irq_out, sys_rst_n, esc_cause, esc_count
  );
endinterface

// File: rtl/watchdog_escalation_ctrl.sv
// Watchdog interrupt escalation: IRQ, ack window, system reset pulse and holdoff.
// Define WDT_ESC_EVT_CNT_EN to build the saturating escalation event counter.
module watchdog_escalation_ctrl #(
  parameter int unsigned ACK_WINDOW = 16,
  parameter int unsigned RST_PULSE  = 8,
  parameter int unsigned HOLDOFF    = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  watchdog_escalation_ctrl_if.slave  bus
);

  localparam logic [15:0] ACK_LAST   = 16'(ACK_WINDOW - 1);
  localparam logic [15:0] PULSE_LAST = 16'(RST_PULSE - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IRQ_PEND,
    S_RST_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic        int_q;
  logic        irq_out_r;
  logic        sys_rst_n_r;
  logic        esc_cause_r;
  logic        evt;
  logic        esc_set;

  assign evt     = bus.interrupt & ~int_q;
  assign esc_set = (state == S_IRQ_PEND) && !bus.irq_ack && (timer == ACK_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      timer       <= '0;
      int_q       <= 1'b0;
      irq_out_r   <= 1'b0;
      sys_rst_n_r <= 1'b1;
      esc_cause_r <= 1'b0;
    end else begin
      int_q <= bus.interrupt;
      // A clear is overridden below when an escalation happens in the same cycle.
      if (bus.cause_clr)
        esc_cause_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (evt) begin
            state     <= S_IRQ_PEND;
            timer     <= '0;
            irq_out_r <= 1'b1;
          end
        end
        S_IRQ_PEND: begin
          if (bus.irq_ack) begin
            state     <= S_IDLE;
            timer     <= '0;
            irq_out_r <= 1'b0;
          end else if (esc_set) begin
            state       <= S_RST_ASSERT;
            timer       <= '0;
            irq_out_r   <= 1'b0;
            sys_rst_n_r <= 1'b0;
            esc_cause_r <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RST_ASSERT: begin
          if (timer == PULSE_LAST) begin
            state       <= S_HOLDOFF;
            timer       <= '0;
            sys_rst_n_r <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_HOLDOFF: begin
          if (timer == HOLD_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          timer       <= '0;
          irq_out_r   <= 1'b0;
          sys_rst_n_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.irq_out   = irq_out_r;
  assign bus.sys_rst_n = sys_rst_n_r;
  assign bus.esc_cause = esc_cause_r;

`ifdef WDT_ESC_EVT_CNT_EN
  logic [7:0] esc_cnt_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      esc_cnt_r <= '0;
    else if (esc_set && (esc_cnt_r != 8'hFF))
      esc_cnt_r <= esc_cnt_r + 8'd1;
  end

  assign bus.esc_count = esc_cnt_r;
`else
  assign bus.esc_count = '0;
`endif

endmodule

// File: tb/tb_watchdog_escalation_ctrl.sv
// Directed bench for watchdog_escalation_ctrl with ACK_WINDOW=8, RST_PULSE=4, HOLDOFF=16.
// Sample index i means the falling edge after the i-th rising edge following the interrupt rise.
module tb_watchdog_escalation_ctrl;

`ifdef WDT_ESC_EVT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  logic irq_s [64];
  logic rst_s [64];

  always #5 clk = ~clk;

  watchdog_escalation_ctrl_if bus ();

  watchdog_escalation_ctrl #(
    .ACK_WINDOW (8),
    .RST_PULSE  (4),
    .HOLDOFF    (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic test_reset();
    bus.interrupt = 1'b0;
    bus.irq_ack   = 1'b0;
    bus.cause_clr = 1'b0;
    rstn = 1'b0;
    #12;
    checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out got=%b exp=0", bus.irq_out); end
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL reset_sys_rst_n got=%b exp=1", bus.sys_rst_n); end
    checks++; if (bus.esc_cause !== 1'b0) begin errors++; $display("FAIL reset_esc_cause got=%b exp=0", bus.esc_cause); end
    checks++; if (bus.esc_count !== 8'd0) begin errors++; $display("FAIL reset_esc_count got=%0d exp=0", bus.esc_count); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ack();
    int  n = 0;
    bit  rst_seen = 1'b0;
    bit  retrig = 1'b0;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.irq_out) n++;
      if (!bus.sys_rst_n) rst_seen = 1'b1;
    end
    bus.irq_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL ack_irq_drop got=%b exp=0", bus.irq_out); end
    // Interrupt level stays high and ack stays asserted in IDLE: neither may retrigger.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.irq_out) retrig = 1'b1;
      if (!bus.sys_rst_n) rst_seen = 1'b1;
    end
    bus.irq_ack = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL ack_irq_len got=%0d exp=4", n); end
    checks++; if (retrig !== 1'b0) begin errors++; $display("FAIL ack_level_retrigger got=%b exp=0", retrig); end
    checks++; if (rst_seen !== 1'b0) begin errors++; $display("FAIL ack_no_reset got=%b exp=0", rst_seen); end
    checks++; if (bus.esc_cause !== 1'b0) begin errors++; $display("FAIL ack_esc_cause got=%b exp=0", bus.esc_cause); end
    bus.interrupt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_escalate();
    int irq_n = 0, rst_n = 0, rst_first = -1;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      irq_s[i] = bus.irq_out;
      rst_s[i] = bus.sys_rst_n;
      if (i == 20) bus.interrupt = 1'b0;
      if (i == 27) bus.interrupt = 1'b1;   // edge lands on the last holdoff cycle
    end
    for (int i = 0; i < 36; i++) begin
      if (irq_s[i]) irq_n++;
      if (!rst_s[i]) begin
        rst_n++;
        if (rst_first < 0) rst_first = i;
      end
    end
    checks++; if (irq_s[0] !== 1'b1) begin errors++; $display("FAIL esc_irq_latency got=%b exp=1", irq_s[0]); end
    checks++; if (irq_n != 8) begin errors++; $display("FAIL esc_irq_len got=%0d exp=8", irq_n); end
    checks++; if (rst_first != 8) begin errors++; $display("FAIL esc_rst_start got=%0d exp=8", rst_first); end
    checks++; if (rst_n != 4) begin errors++; $display("FAIL esc_rst_len got=%0d exp=4", rst_n); end
    checks++; if (bus.esc_cause !== 1'b1) begin errors++; $display("FAIL esc_cause got=%b exp=1", bus.esc_cause); end
    checks++; if (bus.esc_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL esc_count1 got=%0d exp=%0d", bus.esc_count, CNT_EN ? 1 : 0); end
    bus.interrupt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ack_last();
    int irq_n = 0, rst_n = 0;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      irq_s[i] = bus.irq_out;
      rst_s[i] = bus.sys_rst_n;
      if (irq_s[i]) irq_n++;
      if (!rst_s[i]) rst_n++;
      if (i == 7) bus.irq_ack = 1'b1;
      if (i == 8) bus.irq_ack = 1'b0;
    end
    checks++; if (irq_n != 8) begin errors++; $display("FAIL acklast_irq_len got=%0d exp=8", irq_n); end
    checks++; if (irq_s[8] !== 1'b0) begin errors++; $display("FAIL acklast_irq_drop got=%b exp=0", irq_s[8]); end
    checks++; if (rst_n != 0) begin errors++; $display("FAIL acklast_no_reset got=%0d exp=0", rst_n); end
    checks++; if (bus.esc_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL acklast_count got=%0d exp=%0d", bus.esc_count, CNT_EN ? 1 : 0); end
    bus.interrupt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_toggle();
    int irq_n = 0, rst_n = 0, rst_first = -1;
    bus.interrupt = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      irq_s[i] = bus.irq_out;
      rst_s[i] = bus.sys_rst_n;
      case (i)
        2:  bus.interrupt = 1'b0;
        4:  bus.interrupt = 1'b1;
        15: bus.interrupt = 1'b0;
        17: bus.interrupt = 1'b1;
        20: bus.interrupt = 1'b0;
        28: bus.interrupt = 1'b1;   // first edge sampled back in IDLE
        32: bus.irq_ack   = 1'b1;
        33: bus.irq_ack   = 1'b0;
        default: ;
      endcase
    end
    for (int i = 0; i < 36; i++) begin
      if (irq_s[i]) irq_n++;
      if (!rst_s[i]) begin
        rst_n++;
        if (rst_first < 0) rst_first = i;
      end
    end
    checks++; if (rst_first != 8) begin errors++; $display("FAIL toggle_no_restart got=%0d exp=8", rst_first); end
    checks++; if (rst_n != 4) begin errors++; $display("FAIL toggle_single_reset got=%0d exp=4", rst_n); end
    checks++; if (irq_s[28] !== 1'b0) begin errors++; $display("FAIL toggle_holdoff_end got=%b exp=0", irq_s[28]); end
    checks++; if (irq_s[29] !== 1'b1) begin errors++; $display("FAIL toggle_fresh_edge got=%b exp=1", irq_s[29]); end
    checks++; if (irq_n != 12) begin errors++; $display("FAIL toggle_irq_total got=%0d exp=12", irq_n); end
    checks++; if (bus.esc_count !== (CNT_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL toggle_count got=%0d exp=%0d", bus.esc_count, CNT_EN ? 2 : 0); end
    bus.interrupt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bus.interrupt = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++; if (bus.sys_rst_n !== 1'b0) begin errors++; $display("FAIL abort_in_pulse got=%b exp=0", bus.sys_rst_n); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.sys_rst_n !== 1'b1) begin errors++; $display("FAIL abort_sys_rst_n got=%b exp=1", bus.sys_rst_n); end
    checks++; if (bus.irq_out !== 1'b0) begin errors++; $display("FAIL abort_irq_out got=%b exp=0", bus.irq_out); end
    checks++; if (bus.esc_cause !== 1'b0) begin errors++; $display("FAIL abort_esc_cause got=%b exp=0", bus.esc_cause); end
    checks++; if (bus.esc_count !== 8'd0) begin errors++; $display("FAIL abort_esc_count got=%0d exp=0", bus.esc_count); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.irq_out !== 1'b1) begin errors++; $display("FAIL level_after_reset got=%b exp=1", bus.irq_out); end
    for (int i = 1; i < 31; i++) begin
      if (i == 7) bus.cause_clr = 1'b1;
      @(negedge clk);
      if (i == 8) begin
        checks++; if (bus.esc_cause !== 1'b1) begin errors++; $display("FAIL clr_vs_set got=%b exp=1", bus.esc_cause); end
      end
      if (i == 9) begin
        checks++; if (bus.esc_cause !== 1'b0) begin errors++; $display("FAIL clr_after got=%b exp=0", bus.esc_cause); end
        bus.cause_clr = 1'b0;
      end
      if (i == 29) bus.interrupt = 1'b0;
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.interrupt = 1'b1;
      repeat (30) @(negedge clk);
      bus.interrupt = 1'b0;
      @(negedge clk);
    end
    checks++; if (bus.esc_count !== (CNT_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", bus.esc_count, CNT_EN ? 255 : 0); end
    checks++; if (bus.esc_cause !== 1'b1) begin errors++; $display("FAIL sat_cause got=%b exp=1", bus.esc_cause); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_escalate();
    test_ack_last();
    test_toggle();
    test_reset_abort();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watchdog_escalation_ctrl.md
WATCHDOG_ESCALATION_CTRL -- requirements
Module: watchdog_escalation_ctrl

Interface
REQ-001 Parameter ACK_WINDOW, default 16: cycles software has to acknowledge a watchdog interrupt before reset escalation (legal range 2..65535).
REQ-002 Parameter RST_PULSE, default 8: cycles sys_rst_n is held low per escalation (legal range 1..255).
REQ-003 Parameter HOLDOFF, default 32: cycles after the reset pulse during which new interrupt edges are ignored (legal range 1..65535).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 interrupt  input  1  level from the upstream watchdog timer; a 0->1 transition is a timeout event.
REQ-007 irq_ack  input  1  software acknowledge, sampled only in IRQ_PEND.
REQ-008 cause_clr  input  1  clears the sticky esc_cause bit.
REQ-009 irq_out  output  1  registered interrupt request to the CPU.
REQ-010 sys_rst_n  output  1  registered active-low system reset request.
REQ-011 esc_cause  output  1  sticky flag: at least one escalation to reset has occurred.
REQ-012 esc_count  output  8  saturating escalation event counter (see Configuration).

Function
REQ-013 Rising-edge detect: a registered copy int_q of interrupt; event = interrupt & ~int_q.
REQ-014 FSM states IDLE, IRQ_PEND, RST_ASSERT, HOLDOFF; a single timer counter, 16 bits wide, is shared by all states and zeroed on every state transition.
REQ-015 IDLE: an event moves the FSM to IRQ_PEND on the next edge, and irq_out=1 in that same cycle (one-cycle latency from the event).
REQ-016 IRQ_PEND: irq_out=1; the counter increments each cycle from 0.
REQ-017 IRQ_PEND: irq_ack=1 in any cycle, including the cycle with counter==ACK_WINDOW-1, returns the FSM to IDLE; ack wins over expiry.
REQ-018 IRQ_PEND: counter==ACK_WINDOW-1 with irq_ack=0 moves the FSM to RST_ASSERT, sets esc_cause, and increments esc_count.
REQ-019 IRQ_PEND: further interrupt edges are ignored (no restart of the window).
REQ-020 RST_ASSERT: irq_out=0 and sys_rst_n=0 for exactly RST_PULSE cycles, then HOLDOFF.
REQ-021 HOLDOFF: sys_rst_n=1 and irq_out=0; edges are ignored; after HOLDOFF cycles the FSM moves to IDLE.
REQ-022 A level interrupt that is still high on returning to IDLE does not retrigger; only a new 0->1 edge does.
REQ-023 irq_ack outside IRQ_PEND has no effect.
REQ-024 cause_clr=1 clears esc_cause next cycle; if it coincides with a set (REQ-018), the set wins.
REQ-025 esc_count saturates at 255 and never wraps.

Reset
REQ-026 rstn=0 asynchronously forces state=IDLE, counter=0, int_q=0, irq_out=0, sys_rst_n=1, esc_cause=0, esc_count=0.
REQ-027 Reset asserted mid-escalation (any state) aborts immediately; sys_rst_n returns to 1 asynchronously.
REQ-028 After rstn deasserts, an interrupt already high counts as an event on the first clock (int_q=0).

Configuration
REQ-029 Macro WDT_ESC_EVT_CNT_EN: when defined, esc_count is implemented per REQ-018/REQ-025.
REQ-030 Without WDT_ESC_EVT_CNT_EN, no counter register exists and esc_count is tied to 8'h00; all other behaviour is unchanged.

Verification (ACK_WINDOW=8, RST_PULSE=4, HOLDOFF=16)
REQ-031 Test 1: interrupt rises, irq_ack pulsed 3 cycles later -> irq_out high for 4 cycles, sys_rst_n stays 1, esc_cause=0.
REQ-032 Test 2: interrupt rises, no ack -> irq_out high for 8 cycles, then sys_rst_n low exactly 4 cycles, esc_cause=1, esc_count=1, then 16 holdoff cycles, then IDLE.
REQ-033 Test 3: irq_ack in the 8th IRQ_PEND cycle -> return to IDLE, no reset pulse.
REQ-034 Test 4: interrupt toggled during IRQ_PEND and HOLDOFF -> no window restart, no extra escalation; a fresh edge after IDLE -> new IRQ_PEND.
REQ-035 Test 5: rstn dropped mid-RST_ASSERT -> sys_rst_n=1 immediately and all outputs at reset values; cause_clr concurrent with escalation -> esc_cause=1.
REQ-036 Test 6: 300 unacked escalations -> esc_count=255 with the macro defined, 0 without it.
